d_mem_arbiter: RTL and testbench
================================

// Module: d_mem_arbiter
// PURPOSE
//  Shares the single data port (port B) of d_mem between two requesters: M0 = CPU load/store unit, M1 = debug/program loader.
//  Round-robin arbitration, one outstanding access at a time, alignment checking before issue.
//  Returns load data, or write completion, on a one-cycle response strobe per requester.
//  Sits between the LSU/loader and d_mem; drives b_en_write, b_en_read, b_addr, b_din, b_size and b_unsigned.
// PARAMETERS
//  ADDR_SIZE  10  byte-address width, matches d_mem
//  WORD_SIZE  32  data width, matches d_mem
//  ERR_CNT_W  8   width of saturating misaligned-access counter
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          synchronous reset, active low
//  mX_req         in   1          X in {0,1}; request valid; hold it and all mX_* fields stable until mX_ready
//  mX_we          in   1          1 = store, 0 = load
//  mX_addr        in   ADDR_SIZE  byte address
//  mX_wdata       in   WORD_SIZE  store data, right-aligned; byte lanes per d_mem rules
//  mX_size        in   2          00 byte, 01 half, 10 word, 11 illegal
//  mX_unsigned    in   1          load zero-extend (1) / sign-extend (0)
//  mX_ready       out  1          request accepted this cycle
//  mX_rvalid      out  1          one-cycle response strobe
//  mX_rdata       out  WORD_SIZE  load data; 0 for stores and errors
//  mX_err         out  1          qualifies mX_rvalid: misaligned or illegal size
//  mem_en_write   out  1          -> d_mem b_en_write
//  mem_en_read    out  1          -> d_mem b_en_read
//  mem_addr       out  ADDR_SIZE  -> b_addr
//  mem_din        out  WORD_SIZE  -> b_din
//  mem_size       out  2          -> b_size
//  mem_unsigned   out  1          -> b_unsigned
//  mem_dout       in   WORD_SIZE  <- b_dout; valid the cycle after a read enable
//  err_count      out  ERR_CNT_W  saturating count of rejected requests
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, last_grant=M1 (M0 wins first tie), err_count=0.
//   All ready/rvalid/err/mem_en_* are 0; rdata and mem_* data fields are 0.
//  FSM states IDLE, RESP.
//  IDLE: grant = the only requester, or on a tie the one not equal to last_grant.
//   Grant cycle: mX_ready=1 for the granted X only.
//   Aligned and legal: drive mem_* combinationally from X; mem_en_write=we, mem_en_read=~we.
//   Misaligned or illegal: no mem_en_* pulse; err_count+1, saturating at all-ones.
//   Register granted id, we and error flag; last_grant<=X; next state RESP.
//  RESP (exactly 1 cycle): mX_rvalid=1 for the latched id.
//   Load: mX_rdata=mem_dout. Store/error: rdata=0. mX_err=latched flag. mem_en_*=0.
//   Next state IDLE.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always an error.
//  Latency: load data arrives 1 cycle after ready. Throughput: one access per 2 cycles.
//   A requester holding req is granted again at the earliest 2 cycles later.
//  Fairness: both requesting continuously -> strict alternation M0,M1,M0,...
//  A requester that drops req before ready is simply not granted (no error).
//  mX_rdata and mX_err are don't-care outside mX_rvalid, but must be driven 0.
//  Reset mid-access: RESP is abandoned; no rvalid follows. The write already issued in the grant cycle stands.
// TESTING
//  1 Reset: hold rst_n=0 with both req=1 -> all ready/rvalid/mem_en = 0, err_count=0.
//  2 M0 store word 0xA5A5_1234 @0x010, then load word @0x010.
//    -> ready@T, m0_rvalid@T+1 err=0; load then returns 0xA5A5_1234.
//  3 M1 load byte signed @0x013, mem word 0x80FF_0000 -> m1_rdata=0xFFFF_FF80.
//    Same access unsigned -> 0x0000_0080.
//  4 Both req continuously for 8 cycles -> grants M0,M1,M0,M1; ready never on both; no mem_en in RESP cycles.
//  5 M0 half @0x001, M0 word @0x002, M1 size=11 -> each rvalid with err=1.
//    No mem_en pulse; err_count=3. After 255+ errors err_count stays at 0xFF.
//  6 Assert rst_n=0 during RESP of a load -> no rvalid; state IDLE; next request served normally.

Source files
------------

// File: rtl/d_mem_arbiter_if.sv
// Requester <-> arbiter handshake bundle; one instance per requester.
interface d_mem_arbiter_if #(
  parameter int unsigned AddrSize = 10,
  parameter int unsigned WordSize = 32
);
  logic                req;
  logic                we;
  logic [AddrSize-1:0] addr;
  logic [WordSize-1:0] wdata;
  logic [1:0]          size;
  logic                is_unsigned;
  logic                ready;
  logic                rvalid;
  logic [WordSize-1:0] rdata;
  logic                err;

  // Requester side (LSU / loader).
  modport master (
    output req, we, addr, wdata, size, is_unsigned,
    input  ready, rvalid, rdata, err
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, size, is_unsigned,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/d_mem_arbiter.sv
// Round-robin arbiter sharing d_mem port B between M0 (LSU) and M1 (debug loader).
// One access in flight; misaligned/illegal requests are answered with err and never reach memory.
module d_mem_arbiter #(
  parameter int unsigned AddrSize = 10,
  parameter int unsigned WordSize = 32,
  parameter int unsigned ErrCntW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  d_mem_arbiter_if.slave      m0_if,
  d_mem_arbiter_if.slave      m1_if,
  output logic                mem_en_write_o,
  output logic                mem_en_read_o,
  output logic [AddrSize-1:0] mem_addr_o,
  output logic [WordSize-1:0] mem_din_o,
  output logic [1:0]          mem_size_o,
  output logic                mem_unsigned_o,
  input  logic [WordSize-1:0] mem_dout_i,
  output logic [ErrCntW-1:0]  err_count_o
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e              state_q;
  logic                gnt_id_q;      // 0 = M0, 1 = M1
  logic                we_q;
  logic                err_q;
  logic                last_grant_q;
  logic [ErrCntW-1:0]  err_cnt_q;

  logic                gnt_valid;
  logic                gnt_id;
  logic                sel_we;
  logic [AddrSize-1:0] sel_addr;
  logic [WordSize-1:0] sel_wdata;
  logic [1:0]          sel_size;
  logic                sel_unsigned;
  logic                sel_err;
  logic                issue;
  logic                resp;

  // Pick the winner and mux its request fields; a tie goes to whoever did not win last.
  always_comb begin
    gnt_valid = rst_n && (state_q == StIdle) && (m0_if.req || m1_if.req);
    gnt_id    = (m0_if.req && m1_if.req) ? ~last_grant_q : m1_if.req;
    if (gnt_id) begin
      sel_we       = m1_if.we;
      sel_addr     = m1_if.addr;
      sel_wdata    = m1_if.wdata;
      sel_size     = m1_if.size;
      sel_unsigned = m1_if.is_unsigned;
    end else begin
      sel_we       = m0_if.we;
      sel_addr     = m0_if.addr;
      sel_wdata    = m0_if.wdata;
      sel_size     = m0_if.size;
      sel_unsigned = m0_if.is_unsigned;
    end
    unique case (sel_size)
      2'b00:   sel_err = 1'b0;
      2'b01:   sel_err = sel_addr[0];
      2'b10:   sel_err = (sel_addr[1:0] != 2'b00);
      default: sel_err = 1'b1;
    endcase
    issue = gnt_valid && !sel_err;
  end

  // Memory port: driven only in a legal grant cycle, otherwise held at zero.
  always_comb begin
    mem_en_write_o = issue && sel_we;
    mem_en_read_o  = issue && !sel_we;
    mem_addr_o     = issue ? sel_addr     : '0;
    mem_din_o      = issue ? sel_wdata    : '0;
    mem_size_o     = issue ? sel_size     : 2'b00;
    mem_unsigned_o = issue ? sel_unsigned : 1'b0;
  end

  // Requester handshake and response; everything is forced low while reset is asserted.
  always_comb begin
    resp          = rst_n && (state_q == StResp);
    m0_if.ready   = gnt_valid && !gnt_id;
    m1_if.ready   = gnt_valid && gnt_id;
    m0_if.rvalid  = resp && !gnt_id_q;
    m1_if.rvalid  = resp && gnt_id_q;
    m0_if.err     = resp && !gnt_id_q && err_q;
    m1_if.err     = resp && gnt_id_q && err_q;
    m0_if.rdata   = (resp && !gnt_id_q && !we_q && !err_q) ? mem_dout_i : '0;
    m1_if.rdata   = (resp && gnt_id_q && !we_q && !err_q) ? mem_dout_i : '0;
    err_count_o   = err_cnt_q;
  end

  // FSM: latch the granted access in IDLE, spend exactly one cycle in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_id_q     <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;   // M0 wins the first tie
      err_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            gnt_id_q     <= gnt_id;
            we_q         <= sel_we;
            err_q        <= sel_err;
            last_grant_q <= gnt_id;
            state_q      <= StResp;
            if (sel_err && (err_cnt_q != '1)) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Self-checking bench for d_mem_arbiter with a behavioural d_mem port-B model and a
// response scoreboard fed at stimulus time and drained on each rvalid strobe.
module tb_d_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mem_en_write;
  logic        mem_en_read;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_dout;
  logic [7:0]  err_count;

  d_mem_arbiter_if #(.AddrSize(10), .WordSize(32)) m0_if ();
  d_mem_arbiter_if #(.AddrSize(10), .WordSize(32)) m1_if ();

  d_mem_arbiter #(.AddrSize(10), .WordSize(32), .ErrCntW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_if          (m0_if),
    .m1_if          (m1_if),
    .mem_en_write_o (mem_en_write),
    .mem_en_read_o  (mem_en_read),
    .mem_addr_o     (mem_addr),
    .mem_din_o      (mem_din),
    .mem_size_o     (mem_size),
    .mem_unsigned_o (mem_unsigned),
    .mem_dout_i     (mem_dout),
    .err_count_o    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          id;
    bit          err;
    logic [31:0] rdata;
  } resp_t;
  resp_t exp_q[$];

  // Little-endian d_mem port-B model: write on the edge, read data registered for next cycle.
  logic [31:0] dmem [256];
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    mem_dout = 32'h0;
  end
  always @(posedge clk) begin
    logic [31:0] w;
    logic [31:0] sh;
    w  = dmem[mem_addr[9:2]];
    sh = w >> (8 * mem_addr[1:0]);
    if (mem_en_write) begin
      case (mem_size)
        2'b00: w[8*mem_addr[1:0] +: 8] = mem_din[7:0];
        2'b01: w[16*mem_addr[1] +: 16] = mem_din[15:0];
        default: w = mem_din;
      endcase
      dmem[mem_addr[9:2]] <= w;
    end
    if (mem_en_read) begin
      case (mem_size)
        2'b00: mem_dout <= mem_unsigned ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        2'b01: mem_dout <= mem_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        default: mem_dout <= w;
      endcase
    end
  end

  // Response monitor: rvalid must follow the previous cycle's ready (unless in reset),
  // and each strobe must match the scoreboard head.
  logic prev_rdy0 = 1'b0;
  logic prev_rdy1 = 1'b0;
  always @(negedge clk) begin
    logic        rv   [2];
    logic        er   [2];
    logic [31:0] rd   [2];
    logic        exrv [2];
    resp_t       e;
    rv[0] = m0_if.rvalid; er[0] = m0_if.err; rd[0] = m0_if.rdata; exrv[0] = prev_rdy0 && rst_n;
    rv[1] = m1_if.rvalid; er[1] = m1_if.err; rd[1] = m1_if.rdata; exrv[1] = prev_rdy1 && rst_n;
    for (int p = 0; p < 2; p++) begin
      total++;
      if (rv[p] !== exrv[p]) begin
        bad++;
        $display("FAIL rvalid_timing m%0d: got %b want %b at %0t", p, rv[p], exrv[p], $time);
      end
      if (rv[p] === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected m%0d: got a response, want none queued", p);
        end else begin
          e = exp_q.pop_front();
          if (e.id != p[0] || er[p] !== e.err || rd[p] !== e.rdata) begin
            bad++;
            $display("FAIL resp m%0d: got err=%b rdata=%h, want m%0d err=%b rdata=%h",
                     p, er[p], rd[p], e.id, e.err, e.rdata);
          end
        end
      end else begin
        total++;
        if (er[p] !== 1'b0 || rd[p] !== 32'h0) begin
          bad++;
          $display("FAIL idle_outputs m%0d: got err=%b rdata=%h, want 0/0", p, er[p], rd[p]);
        end
      end
    end
    prev_rdy0 = m0_if.ready;
    prev_rdy1 = m1_if.ready;
  end

  task automatic drive(input bit id, input bit req, input bit we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input bit uns);
    if (!id) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr;
      m0_if.wdata = wdata; m0_if.size = size; m0_if.is_unsigned = uns;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr;
      m1_if.wdata = wdata; m1_if.size = size; m1_if.is_unsigned = uns;
    end
  endtask

  // Raise a request, optionally queue its expected response, hold until ready, then drop.
  task automatic issue(input bit id, input bit we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                       input bit push, input bit exp_err, input logic [31:0] exp_rdata,
                       output bit saw_wr, output bit saw_rd, output logic [9:0] saw_addr);
    bit got;
    resp_t e;
    got = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0; saw_addr = '0;
    if (push) begin
      e.id = id; e.err = exp_err; e.rdata = exp_rdata;
      exp_q.push_back(e);
    end
    drive(id, 1'b1, we, addr, wdata, size, uns);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if ((id ? m1_if.ready : m0_if.ready) === 1'b1) begin
        got = 1'b1;
        saw_wr = mem_en_write; saw_rd = mem_en_read; saw_addr = mem_addr;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ready_timeout m%0d: got no ready in 20 cycles, want ready", id);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 10'h010, 32'h0, 2'b10, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 10'h020, 32'h1, 2'b10, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m0_if.ready, m1_if.ready, m0_if.rvalid, m1_if.rvalid} !== 4'b0) begin
      bad++;
      $display("FAIL reset_handshake: got rdy=%b%b rv=%b%b, want 0000",
               m0_if.ready, m1_if.ready, m0_if.rvalid, m1_if.rvalid);
    end
    total++;
    if ({mem_en_write, mem_en_read} !== 2'b00 || mem_addr !== 10'h0 || mem_din !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem: got en=%b%b addr=%h din=%h, want 00/0/0",
               mem_en_write, mem_en_read, mem_addr, mem_din);
    end
    total++;
    if (err_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_errcnt: got %h want 00", err_count);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    bit wr, rd;
    logic [9:0] a;
    issue(1'b0, 1'b1, 10'h010, 32'hA5A5_1234, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, wr, rd, a);
    total++;
    if (wr !== 1'b1 || rd !== 1'b0 || a !== 10'h010) begin
      bad++;
      $display("FAIL store_issue: got wr=%b rd=%b addr=%h, want 1/0/010", wr, rd, a);
    end
    issue(1'b0, 1'b0, 10'h010, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 32'hA5A5_1234, wr, rd, a);
    total++;
    if (wr !== 1'b0 || rd !== 1'b1) begin
      bad++;
      $display("FAIL load_issue: got wr=%b rd=%b, want 0/1", wr, rd);
    end
    settle();
  endtask

  task automatic test_byte_ext();
    bit wr, rd;
    logic [9:0] a;
    issue(1'b1, 1'b1, 10'h010, 32'h80FF_0000, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, wr, rd, a);
    issue(1'b1, 1'b0, 10'h013, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF80, wr, rd, a);
    issue(1'b1, 1'b0, 10'h013, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0000_0080, wr, rd, a);
    settle();
  endtask

  task automatic test_back_to_back();
    bit order[$];
    resp_t e;
    e = '{id: 1'b0, err: 1'b0, rdata: 32'h80FF_0000}; exp_q.push_back(e);
    e = '{id: 1'b1, err: 1'b0, rdata: 32'h0000_80FF}; exp_q.push_back(e);
    e = '{id: 1'b0, err: 1'b0, rdata: 32'hFFFF_FFFF}; exp_q.push_back(e);
    e = '{id: 1'b1, err: 1'b0, rdata: 32'hFFFF_80FF}; exp_q.push_back(e);
    fork
      begin
        bit wr, rd;
        logic [9:0] a;
        issue(1'b0, 1'b0, 10'h010, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, wr, rd, a);
        issue(1'b0, 1'b0, 10'h012, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, wr, rd, a);
      end
      begin
        bit wr, rd;
        logic [9:0] a;
        issue(1'b1, 1'b0, 10'h012, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, wr, rd, a);
        issue(1'b1, 1'b0, 10'h012, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, wr, rd, a);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          total++;
          if (m0_if.ready === 1'b1 && m1_if.ready === 1'b1) begin
            bad++;
            $display("FAIL both_ready cycle %0d: got both ready, want at most one", c);
          end
          total++;
          if ((m0_if.rvalid || m1_if.rvalid) && (mem_en_write || mem_en_read)) begin
            bad++;
            $display("FAIL en_in_resp cycle %0d: got en=%b%b, want 00", c,
                     mem_en_write, mem_en_read);
          end
          if (m0_if.ready === 1'b1) order.push_back(1'b0);
          if (m1_if.ready === 1'b1) order.push_back(1'b1);
        end
      end
    join
    total++;
    if (order.size() != 4 || order[0] != 1'b0 || order[1] != 1'b1 ||
        order[2] != 1'b0 || order[3] != 1'b1) begin
      bad++;
      $display("FAIL grant_order: got %0d grants %p, want M0,M1,M0,M1", order.size(), order);
    end
    settle();
  endtask

  task automatic test_errors();
    bit wr, rd;
    logic [9:0] a;
    issue(1'b0, 1'b0, 10'h001, 32'h0, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0, wr, rd, a);
    total++;
    if (wr !== 1'b0 || rd !== 1'b0) begin
      bad++;
      $display("FAIL err_half_en: got en=%b%b want 00", wr, rd);
    end
    issue(1'b0, 1'b1, 10'h002, 32'h1234, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0, wr, rd, a);
    total++;
    if (wr !== 1'b0 || rd !== 1'b0) begin
      bad++;
      $display("FAIL err_word_en: got en=%b%b want 00", wr, rd);
    end
    issue(1'b1, 1'b0, 10'h000, 32'h0, 2'b11, 1'b0, 1'b1, 1'b1, 32'h0, wr, rd, a);
    total++;
    if (wr !== 1'b0 || rd !== 1'b0) begin
      bad++;
      $display("FAIL err_size_en: got en=%b%b want 00", wr, rd);
    end
    total++;
    if (err_count !== 8'd3) begin
      bad++;
      $display("FAIL err_count3: got %0d want 3", err_count);
    end
    for (int i = 0; i < 253; i++) begin
      issue(1'b0, 1'b0, 10'h003, 32'h0, 2'b11, 1'b0, 1'b1, 1'b1, 32'h0, wr, rd, a);
    end
    total++;
    if (err_count !== 8'hFF) begin
      bad++;
      $display("FAIL err_count_sat: got %h want ff", err_count);
    end
    issue(1'b1, 1'b0, 10'h001, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0, wr, rd, a);
    total++;
    if (err_count !== 8'hFF) begin
      bad++;
      $display("FAIL err_count_hold: got %h want ff", err_count);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    bit wr, rd;
    logic [9:0] a;
    issue(1'b0, 1'b0, 10'h010, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, wr, rd, a);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (m0_if.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_rvalid: got %b want 0", m0_if.rvalid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (m0_if.rvalid !== 1'b0 || err_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_after: got rvalid=%b errcnt=%h want 0/00",
               m0_if.rvalid, err_count);
    end
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 10'h010, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h80FF_0000, wr, rd, a);
    total++;
    if (rd !== 1'b1 || a !== 10'h010) begin
      bad++;
      $display("FAIL reset_mid_next: got rd=%b addr=%h want 1/010", rd, a);
    end
    settle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    test_reset();
    test_store_load();
    test_byte_ext();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_responses: got %0d outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
